// File: rtl/mem_pkg.sv
// ---------------------------------------------------------------------------
// mem_pkg
//   Shared definitions for the memory-stage load/store unit:
//     - lsu_state_e : control FSM states
//     - MRT_*       : load type codes carried on mrtype
//     - RESP_OKAY   : bus response code for a successful transfer
//     - is_misaligned() : alignment rule for loads
// ---------------------------------------------------------------------------
package mem_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD_ADDR = 3'd1,
    RD_DATA = 3'd2,
    WR_REQ  = 3'd3,
    WR_RESP = 3'd4,
    DONE    = 3'd5
  } lsu_state_e;

  localparam logic [2:0] MRT_LB  = 3'd0;
  localparam logic [2:0] MRT_LH  = 3'd1;
  localparam logic [2:0] MRT_LW  = 3'd2;
  localparam logic [2:0] MRT_LBU = 3'd4;
  localparam logic [2:0] MRT_LHU = 3'd5;

  localparam logic [1:0] RESP_OKAY = 2'b00;

  // Byte loads are always aligned, halfword loads need an even address, and
  // word loads (including reserved codes, which behave as LW) need addr[1:0]==0.
  function automatic logic is_misaligned(input logic [2:0] mrtype,
                                         input logic [1:0] off);
    logic mis;
    case (mrtype)
      MRT_LB, MRT_LBU: mis = 1'b0;
      MRT_LH, MRT_LHU: mis = off[0];
      default:         mis = (off != 2'b00);
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/load_extend.sv
// ---------------------------------------------------------------------------
// load_extend
//   Combinational lane select and sign/zero extension of a 32-bit bus word.
//   Ports:
//     word    : aligned word returned by the bus
//     addr_lo : byte offset within the word (addr[1:0])
//     mrtype  : load type (LB/LH/LW/LBU/LHU; reserved codes pass the word)
//     result  : extended load data
// ---------------------------------------------------------------------------
module load_extend
  import mem_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  addr_lo,
  input  logic [2:0]  mrtype,
  output logic [31:0] result
);

  // Bring the addressed byte/halfword down to bit 0.
  logic [31:0] shifted;
  assign shifted = word >> {addr_lo, 3'b000};

  // NOTE: every always_comb output gets a default first so no path can leave
  // it unassigned and infer a latch.
  always_comb begin
    result = word;
    case (mrtype)
      MRT_LB:  result = {{24{shifted[7]}},  shifted[7:0]};
      MRT_LBU: result = {24'b0,             shifted[7:0]};
      MRT_LH:  result = {{16{shifted[15]}}, shifted[15:0]};
      MRT_LHU: result = {16'b0,             shifted[15:0]};
      default: result = word;
    endcase
  end

endmodule

// File: rtl/mstage_lsu.sv
// ---------------------------------------------------------------------------
// mstage_lsu
//   Memory-stage load/store unit. Accepts one instruction at a time from the
//   X->M register (s_valid/s_ready), performs at most one AXI4-Lite-style
//   read or write, and hands the extended load data to writeback
//   (m_valid/m_ready). Non-memory instructions and misaligned loads go
//   straight to DONE without touching the bus.
//   Ports:
//     clk, rst                   : clock, asynchronous active-low reset
//     s_valid/s_ready            : upstream handshake
//     mvalid, mwen, mwmask,
//     mrtype, addr, wdata_in     : instruction fields (captured on accept)
//     ar*/r*                     : read address / read data channels
//     aw*/w*/b*                  : write address / data / response channels
//     m_valid/m_ready            : writeback handshake
//     ldata, err                 : extended load data, bus or alignment error
// ---------------------------------------------------------------------------
module mstage_lsu
  import mem_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,

  input  logic              s_valid,
  output logic              s_ready,
  input  logic              mvalid,
  input  logic              mwen,
  input  logic [7:0]        mwmask,
  input  logic [2:0]        mrtype,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata_in,

  output logic [ADDR_W-1:0] araddr,
  output logic              arvalid,
  input  logic              arready,
  input  logic [DATA_W-1:0] rdata,
  input  logic [1:0]        rresp,
  input  logic              rvalid,
  output logic              rready,

  output logic [ADDR_W-1:0] awaddr,
  output logic              awvalid,
  input  logic              awready,
  output logic [DATA_W-1:0] wdata,
  output logic [3:0]        wstrb,
  output logic              wvalid,
  input  logic              wready,
  input  logic [1:0]        bresp,
  input  logic              bvalid,
  output logic              bready,

  output logic              m_valid,
  input  logic              m_ready,
  output logic [31:0]       ldata,
  output logic              err
);

  lsu_state_e state, state_nxt;

  // Captured instruction fields.
  logic              mvalid_q;
  logic              mwen_q;
  logic [3:0]        mwmask_q;
  logic [2:0]        mrtype_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;

  // Per-channel completion of the write request.
  logic aw_done, w_done;

  logic [31:0] ldata_q;
  logic        err_q;
  logic [31:0] ext_data;

  logic accept;
  logic load_mis;

  // The upper half of the store mask belongs to a wider datapath; only the
  // low nibble addresses this 32-bit bus.
  logic unused_mwmask_hi;
  assign unused_mwmask_hi = ^mwmask[7:4];

  assign accept   = s_valid && s_ready;
  assign load_mis = !mwen && is_misaligned(mrtype, addr[1:0]);

  load_extend u_load_extend (
    .word    (rdata),
    .addr_lo (addr_q[1:0]),
    .mrtype  (mrtype_q),
    .result  (ext_data)
  );

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values of its inputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  // --------------------------------------------------------------------------
  // Next state and handshake outputs. All bus outputs depend only on state
  // and registered flags, never combinationally on a slave ready/valid.
  // --------------------------------------------------------------------------
  always_comb begin
    state_nxt = state;
    s_ready   = 1'b0;
    arvalid   = 1'b0;
    rready    = 1'b0;
    awvalid   = 1'b0;
    wvalid    = 1'b0;
    bready    = 1'b0;
    m_valid   = 1'b0;

    case (state)
      IDLE: begin
        s_ready = 1'b1;
        if (accept) begin
          if (!mvalid)      state_nxt = DONE;
          else if (load_mis) state_nxt = DONE;
          else if (!mwen)   state_nxt = RD_ADDR;
          else              state_nxt = WR_REQ;
        end
      end

      RD_ADDR: begin
        arvalid = 1'b1;
        if (arready) state_nxt = RD_DATA;
      end

      RD_DATA: begin
        rready = 1'b1;
        if (rvalid) state_nxt = DONE;
      end

      WR_REQ: begin
        awvalid = !aw_done;
        wvalid  = !w_done;
        // A channel counts as finished if it already was, or handshakes now;
        // this covers both channels completing in the same cycle.
        if ((aw_done || awready) && (w_done || wready)) state_nxt = WR_RESP;
      end

      WR_RESP: begin
        bready = 1'b1;
        if (bvalid) state_nxt = DONE;
      end

      DONE: begin
        m_valid = 1'b1;
        if (m_ready) state_nxt = IDLE;
      end

      default: state_nxt = IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // Datapath registers
  // --------------------------------------------------------------------------
  // NOTE: every datapath flop is reset because its value is visible on an
  // output port (addresses, data, strobes, ldata, err) straight out of reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mvalid_q <= 1'b0;
      mwen_q   <= 1'b0;
      mwmask_q <= '0;
      mrtype_q <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      aw_done  <= 1'b0;
      w_done   <= 1'b0;
      ldata_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            mvalid_q <= mvalid;
            mwen_q   <= mwen;
            mwmask_q <= mwmask[3:0];
            mrtype_q <= mrtype;
            addr_q   <= addr;
            wdata_q  <= wdata_in;
            aw_done  <= 1'b0;
            w_done   <= 1'b0;
            ldata_q  <= '0;
            // A misaligned load reports its error without any bus access.
            err_q    <= mvalid && load_mis;
          end
        end

        RD_DATA: begin
          // Data is captured even on an error response.
          if (rvalid && mvalid_q) begin
            ldata_q <= ext_data;
            err_q   <= (rresp != RESP_OKAY);
          end
        end

        WR_REQ: begin
          if (awvalid && awready) aw_done <= 1'b1;
          if (wvalid && wready)   w_done  <= 1'b1;
        end

        WR_RESP: begin
          if (bvalid) err_q <= (bresp != RESP_OKAY);
        end

        default: ;
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Bus address/data are word-aligned views of the captured fields.
  // --------------------------------------------------------------------------
  assign araddr = {addr_q[ADDR_W-1:2], 2'b00};
  assign awaddr = {addr_q[ADDR_W-1:2], 2'b00};
  assign wstrb  = mwmask_q << addr_q[1:0];
  assign wdata  = wdata_q << {addr_q[1:0], 3'b000};

  assign ldata  = ldata_q;
  assign err    = err_q;

  // Byte-lane logic assumes a 32-bit data bus; rdata feeds load_extend directly.
  logic unused_mwen_q;
  assign unused_mwen_q = mwen_q;

endmodule

// File: tb/tb_mstage_lsu.sv
// ---------------------------------------------------------------------------
// tb_mstage_lsu
//   Drives mstage_lsu with directed and random instructions against a bus
//   slave with programmable per-channel wait states, and compares bus
//   requests and writeback results to a behavioural model of the unit.
// ---------------------------------------------------------------------------
module tb_mstage_lsu;

  logic        clk, rst;
  logic        s_valid, s_ready;
  logic        mvalid, mwen;
  logic [7:0]  mwmask;
  logic [2:0]  mrtype;
  logic [31:0] addr, wdata_in;
  logic [31:0] araddr;
  logic        arvalid, arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid, rready;
  logic [31:0] awaddr;
  logic        awvalid, awready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wvalid, wready;
  logic [1:0]  bresp;
  logic        bvalid, bready;
  logic        m_valid, m_ready;
  logic [31:0] ldata;
  logic        err;

  int n_checks = 0;
  int n_errors = 0;

  mstage_lsu #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .rst(rst),
    .s_valid(s_valid), .s_ready(s_ready),
    .mvalid(mvalid), .mwen(mwen), .mwmask(mwmask), .mrtype(mrtype),
    .addr(addr), .wdata_in(wdata_in),
    .araddr(araddr), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
    .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
    .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .m_valid(m_valid), .m_ready(m_ready), .ldata(ldata), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish (got running, want finished)");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h want 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- behavioural reference ----------------
  function automatic logic [31:0] ref_load(input logic [31:0] w, input logic [1:0] off,
                                           input logic [2:0] t);
    int unsigned sh, b, h;
    sh = w >> (8 * off);
    b  = sh % 256;
    h  = sh % 65536;
    case (t)
      3'd0:    return (b >= 128) ? b + 32'hFFFF_FF00 : b;
      3'd1:    return (h >= 32768) ? h + 32'hFFFF_0000 : h;
      3'd4:    return b;
      3'd5:    return h;
      default: return w;
    endcase
  endfunction

  function automatic bit ref_misaligned(input logic [2:0] t, input logic [1:0] off);
    if (t == 3'd0 || t == 3'd4) return 1'b0;
    if (t == 3'd1 || t == 3'd5) return (off % 2) != 0;
    return off != 0;
  endfunction

  typedef struct {
    logic        mvalid;
    logic        mwen;
    logic [7:0]  mask;
    logic [2:0]  rtype;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [31:0] rd;
    logic [1:0]  resp;
    int          ar_d, r_d, aw_d, w_d, b_d;
    int          hold;
    bit          mready_hi;
    int          exp_lat;
  } op_t;

  function automatic op_t new_op();
    op_t o;
    o.mvalid = 1'b1; o.mwen = 1'b0; o.mask = 8'h0F; o.rtype = 3'd2;
    o.addr = 32'h0; o.wd = 32'h0; o.rd = 32'h0; o.resp = 2'b00;
    o.ar_d = 0; o.r_d = 0; o.aw_d = 0; o.w_d = 0; o.b_d = 0;
    o.hold = 0; o.mready_hi = 1'b1; o.exp_lat = -1;
    return o;
  endfunction

  // Run one instruction through the unit, acting as bus slave and writeback.
  task automatic run_op(input op_t op);
    logic [31:0] e_ld, e_aaddr, e_wdata;
    logic [3:0]  e_strb;
    logic        e_err;
    bit          mis, got, aw_hs, w_hs;
    int          cyc, arw, rw, aww, ww, bw, bus_seen;
    int unsigned off;

    off     = op.addr[1:0];
    mis     = op.mvalid && !op.mwen && ref_misaligned(op.rtype, op.addr[1:0]);
    e_aaddr = op.addr - off;
    e_strb  = 4'((op.mask % 16) << off);
    e_wdata = op.wd << (8 * off);
    if (!op.mvalid)   begin e_ld = 0; e_err = 0; end
    else if (mis)     begin e_ld = 0; e_err = 1; end
    else if (!op.mwen) begin e_ld = ref_load(op.rd, op.addr[1:0], op.rtype); e_err = (op.resp != 0); end
    else              begin e_ld = 0; e_err = (op.resp != 0); end

    @(negedge clk);
    check("s_ready_before_accept", s_ready, 1);
    s_valid = 1'b1; mvalid = op.mvalid; mwen = op.mwen; mwmask = op.mask;
    mrtype = op.rtype; addr = op.addr; wdata_in = op.wd;
    m_ready = op.mready_hi;
    @(negedge clk);
    // Fields are free to change once accepted.
    s_valid = 1'b0; mvalid = 1'($urandom); mwen = 1'($urandom); mwmask = 8'($urandom);
    mrtype = 3'($urandom); addr = $urandom; wdata_in = $urandom;

    cyc = 0; got = 0; arw = 0; rw = 0; aww = 0; ww = 0; bw = 0; bus_seen = 0;
    aw_hs = 0; w_hs = 0;
    while (!got && cyc < 100) begin
      cyc++;
      // Any ready/valid raised last cycle completed a handshake at the edge.
      if (arready) begin check("arvalid_drop", arvalid, 0); arready = 1'b0; end
      if (rvalid)  begin check("rready_drop",  rready,  0); rvalid  = 1'b0; rdata = $urandom; rresp = 2'($urandom); end
      if (awready) begin check("awvalid_drop", awvalid, 0); awready = 1'b0; end
      if (wready)  begin check("wvalid_drop",  wvalid,  0); wready  = 1'b0; end
      if (bvalid)  begin check("bready_drop",  bready,  0); bvalid  = 1'b0; bresp = 2'($urandom); end
      if (!s_valid) check("s_ready_busy", s_ready, 0);
      if (m_valid) got = 1;
      else begin
        if (arvalid) begin
          bus_seen++;
          check("araddr", araddr, e_aaddr);
          if (arw >= op.ar_d) arready = 1'b1; else arw++;
        end
        if (rready) begin
          bus_seen++;
          if (rw >= op.r_d) begin rvalid = 1'b1; rdata = op.rd; rresp = op.resp; end
          else rw++;
        end
        if (awvalid) begin
          bus_seen++;
          check("awaddr", awaddr, e_aaddr);
          if (aww >= op.aw_d) begin awready = 1'b1; aw_hs = 1; end else aww++;
        end
        if (wvalid) begin
          bus_seen++;
          check("wdata", wdata, e_wdata);
          check("wstrb", {28'b0, wstrb}, {28'b0, e_strb});
          if (ww >= op.w_d) begin wready = 1'b1; w_hs = 1; end else ww++;
        end
        if (bready) begin
          bus_seen++;
          check("wr_resp_after_both", {30'b0, aw_hs, w_hs}, 32'h3);
          if (bw >= op.b_d) begin bvalid = 1'b1; bresp = op.resp; end else bw++;
        end
        @(negedge clk);
      end
    end

    if (!got) begin
      check("m_valid_timeout", 0, 1);
      m_ready = 1'b0;
      return;
    end
    if (op.exp_lat >= 0) check("latency", cyc, op.exp_lat);
    if (!op.mvalid || mis) check("no_bus_activity", bus_seen, 0);
    check("ldata", ldata, e_ld);
    check("err", {31'b0, err}, {31'b0, e_err});
    check("bus_idle_in_done", {27'b0, arvalid, rready, awvalid, wvalid, bready}, 0);

    if (!op.mready_hi) begin
      for (int i = 0; i < op.hold; i++) begin
        @(negedge clk);
        check("hold_m_valid", m_valid, 1);
        check("hold_ldata", ldata, e_ld);
        check("hold_err", {31'b0, err}, {31'b0, e_err});
        check("hold_s_ready", s_ready, 0);
      end
      m_ready = 1'b1;
    end
    @(negedge clk);
    m_ready = 1'b0;
    check("done_one_cycle", m_valid, 0);
    check("s_ready_after_done", s_ready, 1);
  endtask

  // ---------------- stimulus ----------------
  op_t op;
  logic [2:0] codes [8] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5, 3'd3, 3'd6, 3'd7};

  initial begin
    rst = 1'b0; s_valid = 0; mvalid = 0; mwen = 0; mwmask = 0; mrtype = 0;
    addr = 0; wdata_in = 0; arready = 0; rdata = 0; rresp = 0; rvalid = 0;
    awready = 0; wready = 0; bresp = 0; bvalid = 0; m_ready = 0;

    #1;
    check("rst_s_ready", s_ready, 1);
    check("rst_valids", {26'b0, arvalid, rready, awvalid, wvalid, bready, m_valid}, 0);
    check("rst_araddr", araddr, 0);
    check("rst_awaddr", awaddr, 0);
    check("rst_wdata", wdata, 0);
    check("rst_wstrb", {28'b0, wstrb}, 0);
    check("rst_ldata", ldata, 0);
    check("rst_err", {31'b0, err}, 0);
    repeat (2) @(negedge clk);
    rst = 1'b1;

    // Non-memory instruction.
    op = new_op(); op.mvalid = 1'b0; op.addr = 32'h0000_1234; op.exp_lat = 1;
    run_op(op);

    // LB / LBU at 0x8000_0003, zero-wait slave.
    op = new_op(); op.rtype = 3'd0; op.addr = 32'h8000_0003; op.rd = 32'h80FF_FFFF; op.exp_lat = 3;
    run_op(op);
    op.rtype = 3'd4;
    run_op(op);

    // SH at 0x1002, AW ready 3 cycles before W.
    op = new_op(); op.mwen = 1'b1; op.rtype = 3'd0; op.addr = 32'h0000_1002;
    op.wd = 32'h0000_BEEF; op.mask = 8'h03; op.aw_d = 0; op.w_d = 3;
    run_op(op);

    // Zero-wait store.
    op = new_op(); op.mwen = 1'b1; op.rtype = 3'd0; op.addr = 32'h0000_2000;
    op.wd = 32'hCAFE_F00D; op.mask = 8'hFF; op.exp_lat = 3;
    run_op(op);

    // Misaligned LW, then a load with an error response.
    op = new_op(); op.rtype = 3'd2; op.addr = 32'h0000_1001; op.exp_lat = 1;
    run_op(op);
    op = new_op(); op.rtype = 3'd2; op.addr = 32'h0000_3000; op.rd = 32'h1234_5678; op.resp = 2'b10;
    run_op(op);

    // DONE held for 5 cycles with m_ready low.
    op = new_op(); op.rtype = 3'd1; op.addr = 32'h0000_4002; op.rd = 32'h9ABC_0011;
    op.resp = 2'b11; op.mready_hi = 1'b0; op.hold = 5;
    run_op(op);

    // Reset asserted during RD_DATA.
    begin
      bit seen_rd;
      seen_rd = 0;
      @(negedge clk);
      s_valid = 1'b1; mvalid = 1'b1; mwen = 1'b0; mrtype = 3'd2; addr = 32'h0000_5000;
      @(negedge clk);
      s_valid = 1'b0;
      for (int i = 0; i < 10 && !seen_rd; i++) begin
        arready = 1'b0;
        if (rready) seen_rd = 1;
        else begin
          if (arvalid) arready = 1'b1;
          @(negedge clk);
        end
      end
      check("reached_rd_data", {31'b0, seen_rd}, 1);
      #2 rst = 1'b0;
      #1;
      check("rst_async_valids", {26'b0, arvalid, rready, awvalid, wvalid, bready, m_valid}, 0);
      check("rst_async_s_ready", s_ready, 1);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      check("post_rst_s_ready", s_ready, 1);
      check("post_rst_m_valid", m_valid, 0);
    end

    // Random instructions.
    for (int n = 0; n < 60; n++) begin
      op = new_op();
      op.mvalid = ($urandom_range(0, 4) != 0);
      op.mwen   = 1'($urandom_range(0, 1));
      op.rtype  = codes[$urandom_range(0, 7)];
      op.addr   = $urandom;
      if (op.rtype == 3'd3 || op.rtype >= 3'd6) op.addr[1:0] = 2'b00;
      if (op.mwen) op.rtype = 3'd0;
      op.mask = 8'($urandom);
      op.wd   = $urandom;
      op.rd   = $urandom;
      op.resp = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      op.ar_d = $urandom_range(0, 3); op.r_d = $urandom_range(0, 3);
      op.aw_d = $urandom_range(0, 3); op.w_d = $urandom_range(0, 3);
      op.b_d  = $urandom_range(0, 3);
      op.mready_hi = 1'($urandom_range(0, 1));
      op.hold = $urandom_range(0, 2);
      run_op(op);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/mstage_lsu.md
# mstage_lsu

Memory-stage load/store unit that consumes the X→M pipeline register through its valid/ready handshake. It performs at most one data-memory transaction per accepted instruction over an AXI4-Lite-style master port. It then presents the extended load data to the writeback stage through a second valid/ready handshake. Non-memory instructions pass through in one cycle without touching the bus.

## Interface
Parameters:
- `ADDR_W`, default 32: bus address width.
- `DATA_W`, default 32: bus data width. Only 32 is supported.

Ports:
- `clk` in 1: the single clock.
- `rst` in 1: reset, asynchronous and active-low.
- `s_valid` in 1: the upstream register holds a valid instruction.
- `s_ready` out 1: this unit is able to accept an instruction.
- `mvalid` in 1: the instruction accesses memory.
- `mwen` in 1: 1 selects a store, 0 selects a load.
- `mwmask` in 8: store byte mask for the aligned access. Bits [3:0] are used and bits [7:4] are ignored.
- `mrtype` in 3: load type. 0=LB, 1=LH, 2=LW, 4=LBU, 5=LHU.
- `addr` in 32: effective address.
- `wdata_in` in 32: store data, right-aligned.
- `araddr` out 32, `arvalid` out 1, `arready` in 1: read address channel.
- `rdata` in 32, `rresp` in 2, `rvalid` in 1, `rready` out 1: read data channel.
- `awaddr` out 32, `awvalid` out 1, `awready` in 1: write address channel.
- `wdata` out 32, `wstrb` out 4, `wvalid` out 1, `wready` in 1: write data channel.
- `bresp` in 2, `bvalid` in 1, `bready` out 1: write response channel.
- `m_valid` out 1: result is valid toward writeback.
- `m_ready` in 1: writeback accepts the result.
- `ldata` out 32: extended load data. It is 0 for stores and non-memory instructions.
- `err` out 1: a bus error response or a misalignment occurred.

## Operation
- States are IDLE, RD_ADDR, RD_DATA, WR_REQ, WR_RESP and DONE.
- `s_ready` = (state==IDLE). Acceptance is `s_valid & s_ready`. On acceptance, `mvalid`, `mwen`, `mwmask`, `mrtype`, `addr` and `wdata_in` are registered. Upstream holds its fields until acceptance.
- On acceptance, the next state is chosen as follows:
  - `!mvalid` → DONE.
  - Misaligned access → DONE with `err`=1 and no bus activity. Misaligned means LW with addr[1:0]≠0, or LH/LHU with addr[0]=1.
  - Load → RD_ADDR.
  - Store → WR_REQ.
- RD_ADDR:
  - `arvalid`=1 and `araddr` = addr & ~3.
  - On `arready` → RD_DATA.
- RD_DATA:
  - `rready`=1.
  - On `rvalid`, capture the extended data → DONE.
  - `err` = (rresp≠0). `ldata` is still captured when `err`=1.
- WR_REQ:
  - `awvalid` and `wvalid` rise together.
  - `awaddr` = addr & ~3, `wstrb` = mwmask[3:0] << addr[1:0], `wdata` = wdata_in << (8·addr[1:0]).
  - Each valid drops independently after its own handshake. Two per-channel done flags track this.
  - When both channels are done, including the case where both complete in the same cycle → WR_RESP.
- WR_RESP:
  - `bready`=1.
  - On `bvalid` → DONE, with `err` = (bresp≠0).
- DONE:
  - `m_valid`=1. `ldata` and `err` are held stable.
  - On `m_ready` → IDLE. The flags are cleared on the next acceptance.
- Load extension:
  - The lane is selected by addr[1:0].
  - LB and LH sign-extend.
  - LBU and LHU zero-extend.
  - LW passes the word through.
  - Reserved `mrtype` values are treated as LW.
- Bus outputs are driven from registered state only. Valid never drops before its ready.

## Timing
- Reset values: state=IDLE, `s_ready`=1, and all valids, readies, addresses, data, strobes, `ldata` and `err` are 0.
- Reset is asserted asynchronously. Any in-flight transaction is abandoned immediately and all valids fall without waiting for their handshakes.
- Non-memory instruction: accepted in cycle 0, `m_valid` in cycle 1.
- Load with zero-wait slave:
  - Accept in cycle 0.
  - `arvalid` in cycle 1, handshaking in cycle 1.
  - `rvalid` sampled in cycle 2 at the earliest.
  - `m_valid` in cycle 3.
- Store with zero-wait slave:
  - Accept in cycle 0.
  - AW and W handshake in cycle 1.
  - `bvalid` in cycle 2.
  - `m_valid` in cycle 3.
- The unit has no pipelining: one instruction is outstanding. `s_ready`=0 from the cycle after acceptance until the cycle after the DONE handshake.
- `m_ready` may be held high permanently, in which case DONE lasts exactly 1 cycle.

## Structure
- Package `mem_pkg` holds:
  - the state enum;
  - the `mrtype` codes (LB/LH/LW/LBU/LHU);
  - the OKAY=2'b00 response constant.
- Sub-module `load_extend` is combinational. Its inputs are word, addr[1:0] and mrtype; its output is the 32-bit result.

## Test plan
- Non-memory instruction, `m_ready`=1: `m_valid` 1 cycle after acceptance, `ldata`=0, and no bus valids are asserted.
- LB at 0x8000_0003 with rdata=0x80FF_FFFF: `araddr`=0x8000_0000 and `ldata`=0xFFFF_FF80. The same access as LBU gives `ldata`=0x0000_0080.
- SH at 0x1002 with wdata_in=0x0000_BEEF and mwmask=0x03, where awready comes 3 cycles before wready: `wstrb`=4'b1100, `wdata`=0xBEEF_0000, `awvalid` drops after its handshake, and WR_RESP is entered only after the W handshake.
- LW at 0x1001: no bus activity, `m_valid` with `err`=1. In a separate case, a load returning rresp=2'b10 gives `err`=1.
- DONE with `m_ready`=0 for 5 cycles: `ldata`, `err` and `m_valid` are held, and `s_ready` stays 0 the whole time.
- `rst` asserted during RD_DATA: `arvalid`, `rready` and `m_valid` fall to 0 immediately. After release the unit returns to IDLE with `s_ready`=1.
